// File: rtl/mem_pkg.sv
// Shared encodings for the SPI memory request arbiter.
package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_e;

  function automatic logic size_legal(input logic [1:0] s);
    return s != SIZE_ILL;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; last_grant moves on every accepted grant.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_if,
  input  logic req_ls,
  input  logic advance,
  output logic grant_valid,
  output logic grant,
  output logic last_grant
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant_valid = req_if | req_ls;
    if (req_if && req_ls) begin
      grant = (last_q == GNT_LS) ? GNT_IF : GNT_LS;
    end else begin
      grant = req_ls ? GNT_LS : GNT_IF;
    end
    last_d = (advance && grant_valid) ? grant : last_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= GNT_LS;
    else       last_q <= last_d;
  end

  assign last_grant = last_q;

endmodule

// File: rtl/mem_req_arbiter.sv
// Fetch vs load/store arbiter in front of the SPI memory controller.
// Define MEM_TIMEOUT_EN to add the WAIT-state watchdog.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [1:0]        ls_size,
  output logic              ls_ready,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic [ADDR_W-1:0] mc_addr,
  output logic              mc_we,
  output logic [DATA_W-1:0] mc_data_in,
  output logic [1:0]        mc_instr_mode,
  output logic              mc_enable,
  input  logic [DATA_W-1:0] mc_data_out,
  input  logic              mc_op_r
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam bit CFG_OK = (GAP_CYCLES >= 1) && (TIMEOUT_CYCLES >= 1);

  state_e state_q, state_d;
  logic   grant_valid, grant, gnt;
  logic   advance;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              err_q, err_d;
  logic              op_r_q, op_r_d;
  logic [GW-1:0]     gap_q, gap_d;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign advance = (state_q == ST_IDLE);

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_if      (if_req),
    .req_ls      (ls_req),
    .advance     (advance),
    .grant_valid (grant_valid),
    .grant       (grant),
    .last_grant  (gnt)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    din_d      = din_q;
    mode_d     = mode_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    err_d      = err_q;
    gap_d      = gap_q;
`ifdef MEM_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          err_d = 1'b0;
          if (grant == GNT_IF) begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            din_d   = '0;
            mode_d  = SIZE_WORD;
            state_d = ST_ISSUE;
          end else begin
            addr_d = ls_addr;
            we_d   = ls_we;
            din_d  = ls_wdata;
            mode_d = ls_size;
            // Illegal size never reaches the controller.
            if (size_legal(ls_size)) begin
              state_d = ST_ISSUE;
            end else begin
              err_d      = 1'b1;
              ls_rdata_d = '0;
              state_d    = ST_RESP;
            end
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (mc_op_r && !op_r_q) begin
          state_d = ST_RESP;
          if (gnt == GNT_IF) if_rdata_d = mc_data_out;
          else ls_rdata_d = we_q ? '0 : mc_data_out;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_RESP;
          if (gnt == GNT_IF) begin
            if_rdata_d = DATA_W'(TIMEOUT_DATA);
          end else begin
            ls_rdata_d = DATA_W'(TIMEOUT_DATA);
            err_d      = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_GAP;
        gap_d   = '0;
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // A level still high from the last transfer must not look like an edge.
    op_r_d = (state_d == ST_ISSUE) ? 1'b0 : mc_op_r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
      mode_q     <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      err_q      <= 1'b0;
      op_r_q     <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      din_q      <= din_d;
      mode_q     <= mode_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      err_q      <= err_d;
      op_r_q     <= op_r_d;
      gap_q      <= gap_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  assign mc_addr       = addr_q;
  assign mc_we         = we_q;
  assign mc_data_in    = din_q;
  assign mc_instr_mode = mode_q;
  assign mc_enable     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign if_ready      = (state_q == ST_RESP) && (gnt == GNT_IF);
  assign ls_ready      = (state_q == ST_RESP) && (gnt == GNT_LS);
  assign ls_err        = ls_ready && err_q;
  assign if_rdata      = if_rdata_q;
  assign ls_rdata      = ls_rdata_q;

  logic busy;
  assign busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                (state_q == ST_RESP);

  a_cfg: assert property (@(posedge clk) CFG_OK)
    else $error("mem_req_arbiter: bad GAP/TIMEOUT configuration");
  a_if_hold: assert property (@(posedge clk) disable iff (reset)
    (busy && gnt == GNT_IF) |-> if_req)
    else $error("if_req dropped before if_ready");
  a_ls_hold: assert property (@(posedge clk) disable iff (reset)
    (busy && gnt == GNT_LS) |-> ls_req)
    else $error("ls_req dropped before ls_ready");

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a small SPI controller model.
module tb_mem_req_arbiter;
  import mem_pkg::*;

  localparam int AW  = 24;
  localparam int DW  = 32;
  localparam int GAP = 2;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_ready;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_ready, ls_err;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic [1:0]    ls_size;
  logic [AW-1:0] mc_addr;
  logic          mc_we, mc_enable;
  logic [DW-1:0] mc_data_in;
  logic [1:0]    mc_instr_mode;
  logic [DW-1:0] mc_data_out;
  logic          mc_op_r;

  mem_req_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_size(ls_size),
    .ls_ready(ls_ready), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mc_addr(mc_addr), .mc_we(mc_we), .mc_data_in(mc_data_in),
    .mc_instr_mode(mc_instr_mode), .mc_enable(mc_enable),
    .mc_data_out(mc_data_out), .mc_op_r(mc_op_r)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Controller model: op_r low one cycle before it rises at lat.
  int            lat = 2;
  int            mcnt = 0;
  logic          hold_op = 1'b0;
  logic [DW-1:0] resp_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      mcnt    = 0;
      mc_op_r = 1'b0;
    end else if (mc_enable) begin
      if (mcnt == lat - 1) mc_op_r = 1'b0;
      if (mcnt == lat) begin
        mc_op_r     = 1'b1;
        mc_data_out = resp_data;
      end
      mcnt++;
    end else begin
      mcnt = 0;
      if (!hold_op) mc_op_r = 1'b0;
    end
  end

  typedef struct {
    logic          is_ls;
    logic          we;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] resp;
    int            lat;
    int            exp_lat;
    logic          exp_en;
    logic [1:0]    exp_mode;
    logic          exp_we;
    logic [DW-1:0] exp_din;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          chk_rd;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    logic got;
    logic saw_en;
    logic rdy, oth;
    string p;
    p = $sformatf("v%0d", idx);
    resp_data = v.resp;
    lat       = v.lat;
    if (v.is_ls) begin
      ls_we = v.we; ls_size = v.size;
      ls_addr = v.addr; ls_wdata = v.wdata; ls_req = 1'b1;
    end else begin
      if_addr = v.addr; if_req = 1'b1;
    end
    got = 1'b0; saw_en = 1'b0; cyc = 0;
    while (!got && cyc < 100) begin
      tick();
      cyc++;
      if (mc_enable) begin
        saw_en = 1'b1;
        if (v.is_ls) begin
          ls_addr = ~v.addr; ls_wdata = ~v.wdata;
          ls_we = ~v.we; ls_size = SIZE_HALF;
        end else begin
          if_addr = ~v.addr;
        end
      end
      rdy = v.is_ls ? ls_ready : if_ready;
      oth = v.is_ls ? if_ready : ls_ready;
      if (rdy) begin
        got = 1'b1;
        chk({p, "_latency"}, cyc, v.exp_lat);
        chk({p, "_other_ready"}, {31'd0, oth}, 0);
        chk({p, "_err"}, {31'd0, ls_err}, {31'd0, v.exp_err});
        if (v.chk_rd)
          chk({p, "_rdata"}, v.is_ls ? ls_rdata : if_rdata, v.exp_rdata);
        if (v.exp_en) begin
          chk({p, "_addr"}, {8'd0, mc_addr}, {8'd0, v.addr});
          chk({p, "_we"}, {31'd0, mc_we}, {31'd0, v.exp_we});
          chk({p, "_mode"}, {30'd0, mc_instr_mode}, {30'd0, v.exp_mode});
          chk({p, "_din"}, mc_data_in, v.exp_din);
        end
      end
    end
    chk({p, "_got_ready"}, {31'd0, got}, 1);
    chk({p, "_enable_seen"}, {31'd0, saw_en}, {31'd0, v.exp_en});
    tick();
    chk({p, "_pulse"}, {30'd0, if_ready, ls_ready}, 0);
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (4) tick();
  endtask

  vec_t vecs[6];

  initial begin
    int   k, cyc, low_run;
    logic prev_en;
    logic [1:0] prev_rdy, cur_rdy;
    logic dropped, got;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, SIZE_WORD, 24'h000010, 32'h0, 32'h12345678,
                2, 4, 1'b1, SIZE_WORD, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, SIZE_BYTE, 24'h000310, 32'h000000AB,
                32'h5555AAAA, 2, 4, 1'b1, SIZE_BYTE, 1'b1, 32'h000000AB,
                32'h0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, SIZE_HALF, 24'h000400, 32'h0, 32'hBEEF1234,
                3, 5, 1'b1, SIZE_HALF, 1'b0, 32'h0, 32'hBEEF1234, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, SIZE_WORD, 24'h000404, 32'h0, 32'hCAFEF00D,
                5, 7, 1'b1, SIZE_WORD, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, SIZE_ILL, 24'h000408, 32'h0, 32'h0,
                2, 1, 1'b0, SIZE_ILL, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, SIZE_WORD, 24'hFFFFFC, 32'h0, 32'hA5A5A5A5,
                2, 4, 1'b1, SIZE_WORD, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1};

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    ls_size = SIZE_WORD; mc_data_out = '0; mc_op_r = 1'b0;
    tick();
    tick();
    chk("rst_ready", {30'd0, if_ready, ls_ready}, 0);
    chk("rst_err", {31'd0, ls_err}, 0);
    chk("rst_enable", {31'd0, mc_enable}, 0);
    chk("rst_addr_we_mode", {6'd0, mc_addr, mc_we, mc_instr_mode}, 0);
    chk("rst_rdata", if_rdata | ls_rdata | mc_data_in, 0);
    reset = 1'b0;
    tick();

    // Contention: both held, grants must alternate starting with IF.
    if_addr = 24'h000100; ls_addr = 24'h000200;
    ls_we = 1'b0; ls_size = SIZE_WORD;
    lat = 2; resp_data = 32'hC0DE0000;
    if_req = 1'b1; ls_req = 1'b1;
    k = 0; cyc = 0; low_run = 0; prev_en = 1'b0; prev_rdy = 2'b00;
    while (k < 8 && cyc < 300) begin
      tick();
      cyc++;
      cur_rdy = {if_ready, ls_ready};
      if (mc_enable && !prev_en) begin
        if (k > 0) chk($sformatf("rr_gap%0d", k), low_run, GAP + 2);
        low_run = 0;
      end
      if (!mc_enable) low_run++;
      prev_en = mc_enable;
      if (prev_rdy != 2'b00)
        chk($sformatf("rr_pulse%0d", k), {30'd0, cur_rdy}, 0);
      if (cur_rdy != 2'b00) begin
        chk($sformatf("rr_order%0d", k), {30'd0, cur_rdy},
            (k % 2 == 0) ? 32'd2 : 32'd1);
        chk($sformatf("rr_rdata%0d", k),
            (k % 2 == 0) ? if_rdata : ls_rdata, resp_data);
        chk($sformatf("rr_addr%0d", k), {8'd0, mc_addr},
            (k % 2 == 0) ? 32'h100 : 32'h200);
        resp_data = resp_data + 1;
        k++;
      end
      prev_rdy = cur_rdy;
    end
    chk("rr_count", k, 8);
    tick();
    if_req = 1'b0; ls_req = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Stale op_r: level held high from the previous transfer.
    hold_op = 1'b1;
    v = '{1'b0, 1'b0, SIZE_WORD, 24'h000020, 32'h0, 32'h11111111,
          2, 4, 1'b1, SIZE_WORD, 1'b0, 32'h0, 32'h11111111, 1'b0, 1'b1};
    run_vec(v, 10);
    chk("stale_pre_op_r", {31'd0, mc_op_r}, 1);
    lat = 4; resp_data = 32'h22222222;
    if_addr = 24'h000024; if_req = 1'b1;
    dropped = 1'b0; got = 1'b0; cyc = 0;
    while (!got && cyc < 100) begin
      tick();
      cyc++;
      if (if_ready) begin
        got = 1'b1;
        chk("stale_fresh_edge", {31'd0, dropped}, 1);
        chk("stale_latency", cyc, 6);
        chk("stale_rdata", if_rdata, 32'h22222222);
      end
      if (!mc_op_r) dropped = 1'b1;
    end
    chk("stale_got_ready", {31'd0, got}, 1);
    tick();
    if_req = 1'b0;
    hold_op = 1'b0;
    repeat (4) tick();

    // Reset while waiting on the controller.
    lat = 1000;
    if_addr = 24'h000030; if_req = 1'b1;
    repeat (3) tick();
    chk("rstw_enable_before", {31'd0, mc_enable}, 1);
    #2 reset = 1'b1;
    #1 chk("rstw_enable_async", {31'd0, mc_enable}, 0);
    if_req = 1'b0;
    tick();
    chk("rstw_no_ready", {30'd0, if_ready, ls_ready}, 0);
    chk("rstw_addr_cleared", {8'd0, mc_addr}, 0);
    reset = 1'b0;
    tick();
    v = '{1'b0, 1'b0, SIZE_WORD, 24'h000034, 32'h0, 32'h0BADCAFE,
          2, 4, 1'b1, SIZE_WORD, 1'b0, 32'h0, 32'h0BADCAFE, 1'b0, 1'b1};
    run_vec(v, 20);

`ifdef MEM_TIMEOUT_EN
    v = '{1'b1, 1'b0, SIZE_WORD, 24'h000500, 32'h0, 32'h0,
          1000, TMO + 2, 1'b1, SIZE_WORD, 1'b0, 32'h0, 32'hDEADBEEF,
          1'b1, 1'b1};
    run_vec(v, 30);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
